// File: rtl/sw_pe_array_param_if.sv
// rtl/sw_pe_array_param_if.sv - database symbol stream handshake for sw_pe_array_param
interface sw_pe_array_param_if #(
  parameter int SYM_W = 2
) ();
  logic             i_valid;
  logic [SYM_W-1:0] i_A;
  logic             i_last;
  logic             o_ready;

  modport master (output i_valid, output i_A, output i_last, input o_ready);
  modport slave  (input i_valid, input i_A, input i_last, output o_ready);
endinterface

// File: rtl/sw_pe_array_param.sv
// rtl/sw_pe_array_param.sv - parametrised Smith-Waterman stripe score array; optional SW_SCORE_SAT_EN saturates cell scores
module sw_pe_array_param #(
  parameter int NUM_PE   = 64,
  parameter int SYM_W    = 2,
  parameter int SCORE_W  = 14,
  parameter int POS_W    = 10,
  parameter int MATCH    = 2,
  parameter int MISMATCH = 1,
  parameter int GAP      = 1
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_load,
  input  logic [NUM_PE*SYM_W-1:0]   i_B,
  sw_pe_array_param_if.slave        a_if,
  output logic                      o_busy,
  output logic                      o_done,
  output logic [SCORE_W-1:0]        o_max_score,
  output logic [POS_W-1:0]          o_max_row,
  output logic [$clog2(NUM_PE)-1:0] o_max_col,
  output logic                      o_sat
);

  localparam int EW    = SCORE_W + 2;
  localparam int CNT_W = $clog2(NUM_PE + 1);
  localparam int COL_W = $clog2(NUM_PE);

  localparam logic signed [EW-1:0] S_MATCH    = EW'(MATCH);
  localparam logic signed [EW-1:0] S_MISMATCH = EW'(MISMATCH);
  localparam logic signed [EW-1:0] S_GAP      = EW'(GAP);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_SCAN, S_DONE} state_t;

  state_t                         state_q, state_d;
  logic [CNT_W-1:0]               cnt_q;
  logic [POS_W-1:0]               row_cnt_q;
  logic [NUM_PE*SYM_W-1:0]        b_q;

  // Per-PE cell state
  logic [NUM_PE-1:0][SCORE_W-1:0] h_q, diag_q, lmax_q;
  logic [NUM_PE-1:0][POS_W-1:0]   lrow_q;

  // Slot pipeline between PEs: stage k feeds PE k+1
  logic [NUM_PE-2:0]              sv_q;
  logic [NUM_PE-2:0][SYM_W-1:0]   sa_q;
  logic [NUM_PE-2:0][POS_W-1:0]   sr_q;

  // Per-PE slot view and cell results
  logic [NUM_PE-1:0]              pe_v;
  logic [NUM_PE-1:0][SYM_W-1:0]   pe_a;
  logic [NUM_PE-1:0][POS_W-1:0]   pe_row;
  logic [NUM_PE-1:0][SCORE_W-1:0] left_v;
  logic [NUM_PE-1:0][SCORE_W-1:0] h_new;

  logic             accept, row_full, last_acc, load_ok;
  logic [COL_W-1:0] scan_idx;

  assign accept   = (state_q == S_RUN) && a_if.i_valid;
  assign row_full = (row_cnt_q == {POS_W{1'b1}});
  assign last_acc = accept && (a_if.i_last || row_full);
  assign load_ok  = i_load && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign scan_idx = cnt_q[COL_W-1:0];

  // Best of diagonal, up and left candidates, floored at zero in widened signed arithmetic
  function automatic logic signed [EW-1:0] cell_score(
    input logic [SCORE_W-1:0] diag,
    input logic [SCORE_W-1:0] up,
    input logic [SCORE_W-1:0] left,
    input logic               eq
  );
    logic signed [EW-1:0] d, u, l, m;
    d = $signed({2'b00, diag}) + (eq ? S_MATCH : -S_MISMATCH);
    u = $signed({2'b00, up}) - S_GAP;
    l = $signed({2'b00, left}) - S_GAP;
    m = '0;
    if (d > m) m = d;
    if (u > m) m = u;
    if (l > m) m = l;
    return m;
  endfunction

`ifdef SW_SCORE_SAT_EN
  logic [NUM_PE-1:0] ovf;
`endif

  for (genvar k = 0; k < NUM_PE; k++) begin : g_pe
    logic signed [EW-1:0] best;

    if (k == 0) begin : g_head
      // PE0 sees the accepted symbol directly; column -1 boundary is zero
      assign pe_v[k]   = accept;
      assign pe_a[k]   = a_if.i_A;
      assign pe_row[k] = row_cnt_q;
      assign left_v[k] = '0;
    end else begin : g_body
      assign pe_v[k]   = sv_q[k-1];
      assign pe_a[k]   = sa_q[k-1];
      assign pe_row[k] = sr_q[k-1];
      assign left_v[k] = h_q[k-1];
    end

    assign best = cell_score(diag_q[k], h_q[k], left_v[k],
                             pe_a[k] == b_q[k*SYM_W +: SYM_W]);

`ifdef SW_SCORE_SAT_EN
    assign ovf[k]   = (best > $signed({2'b00, {SCORE_W{1'b1}}}));
    assign h_new[k] = ovf[k] ? {SCORE_W{1'b1}} : SCORE_W'(best);
`else
    assign h_new[k] = SCORE_W'(best);
`endif
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and status outputs
  always_comb begin
    state_d      = state_q;
    a_if.o_ready = 1'b0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (load_ok) state_d = S_RUN;
      end
      S_RUN: begin
        a_if.o_ready = 1'b1;
        o_busy       = 1'b1;
        if (last_acc) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        o_busy = 1'b1;
        if (cnt_q == CNT_W'(NUM_PE)) state_d = S_SCAN;
      end
      S_SCAN: begin
        o_busy = 1'b1;
        if (cnt_q == CNT_W'(NUM_PE - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        o_done  = 1'b1;
        state_d = load_ok ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Phase counter for DRAIN and SCAN, restarted on every state change
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                                         cnt_q <= '0;
    else if (state_q != state_d)                        cnt_q <= '0;
    else if ((state_q == S_DRAIN) || (state_q == S_SCAN)) cnt_q <= cnt_q + 1'b1;
  end

  // Query latch and saturating row counter
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      b_q       <= '0;
      row_cnt_q <= '0;
    end else if (load_ok) begin
      b_q       <= i_B;
      row_cnt_q <= '0;
    end else if (accept && !row_full) begin
      row_cnt_q <= row_cnt_q + 1'b1;
    end
  end

  // Systolic slot shift and PE cell/local-max update, gated by slot valid
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      h_q    <= '0;
      diag_q <= '0;
      lmax_q <= '0;
      lrow_q <= '0;
      sv_q   <= '0;
      sa_q   <= '0;
      sr_q   <= '0;
    end else if (load_ok) begin
      h_q    <= '0;
      diag_q <= '0;
      lmax_q <= '0;
      lrow_q <= '0;
      sv_q   <= '0;
    end else begin
      sv_q[0] <= pe_v[0];
      sa_q[0] <= pe_a[0];
      sr_q[0] <= pe_row[0];
      for (int k = 1; k < NUM_PE - 1; k++) begin
        sv_q[k] <= sv_q[k-1];
        sa_q[k] <= sa_q[k-1];
        sr_q[k] <= sr_q[k-1];
      end
      for (int k = 0; k < NUM_PE; k++) begin
        if (pe_v[k]) begin
          h_q[k]    <= h_new[k];
          diag_q[k] <= left_v[k];
          if (h_new[k] > lmax_q[k]) begin
            lmax_q[k] <= h_new[k];
            lrow_q[k] <= pe_row[k];
          end
        end
      end
    end
  end

  // Column scan: strictly-greater replacement keeps the lowest column on ties
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_max_score <= '0;
      o_max_row   <= '0;
      o_max_col   <= '0;
    end else if (load_ok) begin
      o_max_score <= '0;
      o_max_row   <= '0;
      o_max_col   <= '0;
    end else if (state_q == S_SCAN) begin
      if (lmax_q[scan_idx] > o_max_score) begin
        o_max_score <= lmax_q[scan_idx];
        o_max_row   <= lrow_q[scan_idx];
        o_max_col   <= scan_idx;
      end
    end
  end

`ifdef SW_SCORE_SAT_EN
  // Sticky flag for any clamped cell in the current stripe
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst)                o_sat <= 1'b0;
    else if (load_ok)          o_sat <= 1'b0;
    else if (|(ovf & pe_v))    o_sat <= 1'b1;
  end
`else
  assign o_sat = 1'b0;
`endif

endmodule

// File: tb/tb_sw_pe_array_param.sv
// tb/tb_sw_pe_array_param.sv - directed self-checking bench for sw_pe_array_param
module tb_sw_pe_array_param;

  logic       clk;
  logic       rst_n;
  logic       load;
  logic [7:0] b_sym;
  logic       valid;
  logic [1:0] a_sym;
  logic       last;

  int checks;
  int failures;
  int cyc;
  int t_last;
  int at;

  logic [1:0] cap_seq [6];

`ifdef SW_SCORE_SAT_EN
  localparam int EXP_S_SCORE = 7;
  localparam int EXP_S_ROW   = 3;
  localparam int EXP_S_COL   = 3;
  localparam int EXP_S_SAT   = 1;
`else
  localparam int EXP_S_SCORE = 6;
  localparam int EXP_S_ROW   = 2;
  localparam int EXP_S_COL   = 2;
  localparam int EXP_S_SAT   = 0;
`endif

  sw_pe_array_param_if #(.SYM_W(2)) if_m ();
  sw_pe_array_param_if #(.SYM_W(2)) if_s ();
  sw_pe_array_param_if #(.SYM_W(2)) if_c ();

  assign if_m.i_valid = valid;
  assign if_m.i_A     = a_sym;
  assign if_m.i_last  = last;
  assign if_s.i_valid = valid;
  assign if_s.i_A     = a_sym;
  assign if_s.i_last  = last;
  assign if_c.i_valid = valid;
  assign if_c.i_A     = a_sym;
  assign if_c.i_last  = last;

  logic        busy_m, done_m, sat_m;
  logic [13:0] score_m;
  logic [9:0]  row_m;
  logic [1:0]  col_m;

  logic        busy_s, done_s, sat_s;
  logic [2:0]  score_s;
  logic [9:0]  row_s;
  logic [1:0]  col_s;

  logic        busy_c, done_c, sat_c;
  logic [13:0] score_c;
  logic [1:0]  row_c;
  logic [1:0]  col_c;

  logic [2:0]  done_v;
  assign done_v = {done_c, done_s, done_m};

  sw_pe_array_param #(.NUM_PE(4), .SYM_W(2), .SCORE_W(14), .POS_W(10)) dut_m (
    .i_clk(clk), .i_rst(rst_n), .i_load(load), .i_B(b_sym), .a_if(if_m),
    .o_busy(busy_m), .o_done(done_m), .o_max_score(score_m), .o_max_row(row_m),
    .o_max_col(col_m), .o_sat(sat_m)
  );

  sw_pe_array_param #(.NUM_PE(4), .SYM_W(2), .SCORE_W(3), .POS_W(10)) dut_s (
    .i_clk(clk), .i_rst(rst_n), .i_load(load), .i_B(b_sym), .a_if(if_s),
    .o_busy(busy_s), .o_done(done_s), .o_max_score(score_s), .o_max_row(row_s),
    .o_max_col(col_s), .o_sat(sat_s)
  );

  sw_pe_array_param #(.NUM_PE(4), .SYM_W(2), .SCORE_W(14), .POS_W(2)) dut_c (
    .i_clk(clk), .i_rst(rst_n), .i_load(load), .i_B(b_sym), .a_if(if_c),
    .o_busy(busy_c), .o_done(done_c), .o_max_score(score_c), .o_max_row(row_c),
    .o_max_col(col_c), .o_sat(sat_c)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Free-running cycle counter used to measure latencies
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_load(input logic [7:0] b);
    load  = 1'b1;
    b_sym = b;
    @(posedge clk); #1;
    load  = 1'b0;
  endtask

  task automatic send(input string tag, input logic [1:0] a, input logic l);
    valid = 1'b1;
    a_sym = a;
    last  = l;
    chk({tag, "_ready"}, 32'(if_m.o_ready), 1);
    @(posedge clk); #1;
    if (l) t_last = cyc;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  task automatic bubble(input string tag);
    valid = 1'b0;
    chk({tag, "_ready_bubble"}, 32'(if_m.o_ready), 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input int which, output int seen);
    seen = -1;
    for (int n = 0; n < 40; n++) begin
      if (done_v[which]) begin
        seen = cyc;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic check_diag(input string tag);
    chk({tag, "_m_score"}, 32'(score_m), 8);
    chk({tag, "_m_row"},   32'(row_m),   3);
    chk({tag, "_m_col"},   32'(col_m),   3);
    chk({tag, "_m_sat"},   32'(sat_m),   0);
    chk({tag, "_m_busy"},  32'(busy_m),  0);
    chk({tag, "_s_done"},  32'(done_s),  1);
    chk({tag, "_s_score"}, 32'(score_s), EXP_S_SCORE);
    chk({tag, "_s_row"},   32'(row_s),   EXP_S_ROW);
    chk({tag, "_s_col"},   32'(col_s),   EXP_S_COL);
    chk({tag, "_s_sat"},   32'(sat_s),   EXP_S_SAT);
    chk({tag, "_c_done"},  32'(done_c),  1);
    chk({tag, "_c_score"}, 32'(score_c), 8);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    t_last   = 0;
    rst_n    = 1'b0;
    load     = 1'b0;
    b_sym    = 8'h00;
    valid    = 1'b0;
    a_sym    = 2'd0;
    last     = 1'b0;
    cap_seq  = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy",  32'(busy_m),       0);
    chk("rst_done",  32'(done_m),       0);
    chk("rst_ready", 32'(if_m.o_ready), 0);
    chk("rst_score", 32'(score_m),      0);
    chk("rst_sat",   32'(sat_s),        0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_ready", 32'(if_m.o_ready), 0);

    // Diagonal match: B=ACGT, A=ACGT
    do_load(8'hE4);
    chk("diag_busy", 32'(busy_m), 1);
    send("diag0", 2'd0, 1'b0);
    send("diag1", 2'd1, 1'b0);
    send("diag2", 2'd2, 1'b0);
    send("diag3", 2'd3, 1'b1);
    chk("diag_ready_after_last", 32'(if_m.o_ready), 0);
    wait_done(0, at);
    chk("diag_latency", 32'(at - t_last), 9);
    check_diag("diag");
    @(posedge clk); #1;
    chk("diag_done_pulse", 32'(done_m), 0);
    chk("diag_idle_busy",  32'(busy_m), 0);
    chk("diag_hold_score", 32'(score_m), 8);

    // All mismatch: B=AAAA, A=CCCC
    do_load(8'h00);
    send("mis0", 2'd1, 1'b0);
    send("mis1", 2'd1, 1'b0);
    send("mis2", 2'd1, 1'b0);
    send("mis3", 2'd1, 1'b1);
    wait_done(0, at);
    chk("mis_latency", 32'(at - t_last), 9);
    chk("mis_m_score", 32'(score_m), 0);
    chk("mis_m_row",   32'(row_m),   0);
    chk("mis_m_col",   32'(col_m),   0);
    chk("mis_m_sat",   32'(sat_m),   0);
    chk("mis_s_score", 32'(score_s), 0);
    chk("mis_s_sat",   32'(sat_s),   0);
    @(posedge clk); #1;

    // Bubbles between every symbol
    do_load(8'hE4);
    send("bub0", 2'd0, 1'b0);
    bubble("bub0");
    send("bub1", 2'd1, 1'b0);
    bubble("bub1");
    send("bub2", 2'd2, 1'b0);
    bubble("bub2");
    send("bub3", 2'd3, 1'b1);
    wait_done(0, at);
    chk("bub_latency", 32'(at - t_last), 9);
    check_diag("bub");
    @(posedge clk); #1;

    // Row-counter cap on the POS_W=2 instance: 4th accept ends the stripe
    do_load(8'hE4);
    for (int i = 0; i < 6; i++) begin
      valid = 1'b1;
      a_sym = cap_seq[i];
      last  = 1'b0;
      chk($sformatf("cap_ready%0d", i), 32'(if_c.o_ready), (i < 4) ? 1 : 0);
      @(posedge clk); #1;
      if (i == 3) t_last = cyc;
    end
    valid = 1'b0;
    wait_done(2, at);
    chk("cap_latency", 32'(at - t_last), 9);
    chk("cap_score",   32'(score_c), 8);
    chk("cap_row",     32'(row_c),   3);
    chk("cap_col",     32'(col_c),   3);
    chk("cap_busy",    32'(busy_c),  0);
    chk("cap_m_still_run", 32'(busy_m), 1);

    // Reset mid-RUN after two accepts
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    do_load(8'hE4);
    send("mid0", 2'd0, 1'b0);
    send("mid1", 2'd1, 1'b0);
    chk("mid_busy_pre", 32'(busy_m), 1);
    rst_n = 1'b0;
    #2;
    chk("mid_busy",  32'(busy_m),       0);
    chk("mid_ready", 32'(if_m.o_ready), 0);
    chk("mid_done",  32'(done_m),       0);
    chk("mid_score", 32'(score_m),      0);
    chk("mid_row",   32'(row_m),        0);
    chk("mid_col",   32'(col_m),        0);
    chk("mid_sat",   32'(sat_s),        0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_idle_ready", 32'(if_m.o_ready), 0);

    // Fresh diagonal stripe after reset
    do_load(8'hE4);
    send("fresh0", 2'd0, 1'b0);
    send("fresh1", 2'd1, 1'b0);
    send("fresh2", 2'd2, 1'b0);
    send("fresh3", 2'd3, 1'b1);
    wait_done(0, at);
    chk("fresh_latency", 32'(at - t_last), 9);
    check_diag("fresh");
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
